mem_rr_arbiter: RTL and testbench
=================================

MEM_RR_ARBITER -- requirements
Module: mem_rr_arbiter

Interface
REQ-001 Parameter M_WIDTH, default 32, memory/data word width in bits.
REQ-002 Parameter CLIENT_CNT, default 4, number of requesters; all per-client buses are packed with client i at slice i.
REQ-003 Port clk  in  1  single clock, all logic on its rising edge.
REQ-004 Port rst  in  1  synchronous, active-high reset.
REQ-005 Port client_requests  in  CLIENT_CNT  per-client access request, held high until that client's ready.
REQ-006 Port client_addrs_packed  in  CLIENT_CNT*M_WIDTH  byte addresses.
REQ-007 Port client_wes  in  CLIENT_CNT  1 = write, 0 = read.
REQ-008 Port client_data_widths_packed  in  CLIENT_CNT*2  00 = 8-bit, 01 = 16-bit, 10 = 32-bit; 11 is treated as 32-bit.
REQ-009 Port client_data_outs_packed  in  CLIENT_CNT*M_WIDTH  write data, right-aligned.
REQ-010 Port client_readies  out  CLIENT_CNT  one-cycle completion pulse per client.
REQ-011 Port client_data_ins_packed  out  CLIENT_CNT*M_WIDTH  read data, right-aligned and zero-extended.
REQ-012 Port mem_addr  out  M_WIDTH-clog2(M_WIDTH/8)  word address, equal to the byte address shifted right by clog2(M_WIDTH/8).
REQ-013 Port mem_data_out  out  M_WIDTH  lane-positioned write data.
REQ-014 Port mem_we_outs  out  M_WIDTH/8  per-byte write enables.
REQ-015 Port mem_data_in  in  M_WIDTH  synchronous memory read word, valid one cycle after mem_addr is presented.

Function
REQ-016 FSM states and transitions: IDLE -> ACCESS -> RESPOND -> IDLE; the arbiter serves exactly one access per 3 cycles.
REQ-017 IDLE, any request high: grant the winning client, and register its index, address, we, width and data; next state is ACCESS.
REQ-018 IDLE, no request: remain in IDLE.
REQ-019 Arbitration is round-robin: priority starts at (last_grant+1) mod CLIENT_CNT; last_grant resets to CLIENT_CNT-1, so client 0 has first priority.
REQ-020 ACCESS: drive mem_addr and mem_data_out from the latched request; drive mem_we_outs only when the access is a write.
REQ-021 Byte lanes: 8-bit uses lane addr[1:0]; 16-bit uses lanes {addr[1],1}/{addr[1],0}, ignoring addr[0]; 32-bit uses all lanes, ignoring addr[1:0].
REQ-022 Write data is shifted left by 8*lane_offset; mem_we_outs has 1, 2 or 4 bits set, matching the selected lanes.
REQ-023 RESPOND: pulse client_readies[granted]=1 for exactly one cycle; hold mem_addr; all mem_we_outs = 0.
REQ-024 RESPOND, read: client_data_ins[granted] = selected lanes of mem_data_in, shifted to bit 0 and zero-extended.
REQ-025 RESPOND, write: client_data_ins[granted] = 0.
REQ-026 Every non-granted client_data_ins is 0 in all states; in IDLE all client_data_ins are 0.
REQ-027 Granted access latency: ready is high 2 cycles after the IDLE cycle in which the request was sampled.
REQ-028 A client that saw ready in cycle N must have its request low in cycle N+1 unless it is issuing a new access; a request still high in N+1 is treated as new.
REQ-029 A request dropped after grant does not abort the access; it completes and ready still pulses.
REQ-030 Request inputs are ignored outside IDLE; inputs of the latched access are not re-sampled.
REQ-031 IDLE outputs: mem_addr = 0, mem_data_out = 0, mem_we_outs = 0, client_readies = 0.

Reset
REQ-032 With rst high at an edge, the next cycle has state = IDLE, last_grant = CLIENT_CNT-1, and all outputs = 0.
REQ-033 Reset mid-access aborts the access: no ready pulse is issued and mem_we_outs is not reasserted.

Verification
REQ-034 Single read: client 1 requests 32-bit read at 0x0000_0010, memory word 4 = 0x12345678 -> mem_addr = 4 in ACCESS; readies = 0010 and data_in[1] = 0x12345678 two cycles after grant.
REQ-035 Byte write: client 3 writes 0xAB at 0x1002 width 00 -> mem_addr = 0x400, mem_we_outs = 0100, mem_data_out = 0x00AB0000 for one cycle; readies[3] then pulses.
REQ-036 Half read: memory word 1 = 0xCAFEBEEF, 16-bit read at 0x6 -> data_in = 0x0000CAFE; the same read at 0x4 -> 0x0000BEEF.
REQ-037 Fairness: all four requests held high continuously -> grant order 0,1,2,3,0; each ready arrives 3 cycles apart; no client is starved.
REQ-038 Reset during ACCESS of a write -> no readies pulse; mem_we_outs = 0 from the cycle after reset; next grant goes to client 0.
REQ-039 Request withdrawn the cycle after grant -> the access still completes; exactly one ready pulse; FSM returns to IDLE.

Source files
------------

// File: rtl/mem_rr_arbiter_if.sv
// Client-side and memory-side signal bundle for the round-robin memory arbiter.
// The arbiter connects through the slave modport; clients and memory use the master modport.
interface mem_rr_arbiter_if #(
  parameter int unsigned M_WIDTH    = 32,
  parameter int unsigned CLIENT_CNT = 4
);
  localparam int unsigned NB = M_WIDTH / 8;
  localparam int unsigned AW = M_WIDTH - $clog2(NB);

  logic [CLIENT_CNT-1:0]         client_requests;
  logic [CLIENT_CNT*M_WIDTH-1:0] client_addrs_packed;
  logic [CLIENT_CNT-1:0]         client_wes;
  logic [CLIENT_CNT*2-1:0]       client_data_widths_packed;
  logic [CLIENT_CNT*M_WIDTH-1:0] client_data_outs_packed;
  logic [CLIENT_CNT-1:0]         client_readies;
  logic [CLIENT_CNT*M_WIDTH-1:0] client_data_ins_packed;
  logic [AW-1:0]                 mem_addr;
  logic [M_WIDTH-1:0]            mem_data_out;
  logic [NB-1:0]                 mem_we_outs;
  logic [M_WIDTH-1:0]            mem_data_in;

  modport slave (
    input  client_requests, client_addrs_packed, client_wes,
    input  client_data_widths_packed, client_data_outs_packed, mem_data_in,
    output client_readies, client_data_ins_packed, mem_addr, mem_data_out, mem_we_outs
  );

  modport master (
    output client_requests, client_addrs_packed, client_wes,
    output client_data_widths_packed, client_data_outs_packed, mem_data_in,
    input  client_readies, client_data_ins_packed, mem_addr, mem_data_out, mem_we_outs
  );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one synchronous memory port among CLIENT_CNT clients.
// Each access takes IDLE -> ACCESS -> RESPOND; sub-word accesses are lane-positioned.
module mem_rr_arbiter #(
  parameter int unsigned M_WIDTH    = 32,
  parameter int unsigned CLIENT_CNT = 4
) (
  input logic            clk,
  input logic            rst,
  mem_rr_arbiter_if.slave bus
);
  localparam int unsigned NB   = M_WIDTH / 8;
  localparam int unsigned OFFW = $clog2(NB);
  localparam int unsigned AW   = M_WIDTH - OFFW;
  localparam int unsigned IW   = (CLIENT_CNT > 1) ? $clog2(CLIENT_CNT) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         grant_q, grant_d, last_q, last_d;
  logic                  we_q, we_d;
  logic [OFFW-1:0]       off_q, off_d;
  logic [1:0]            width_q, width_d;
  logic [AW-1:0]         mem_addr_q, mem_addr_d;
  logic [M_WIDTH-1:0]    mem_data_q, mem_data_d;
  logic [NB-1:0]         mem_we_q, mem_we_d;
  logic [CLIENT_CNT-1:0] readies_q, readies_d;

  logic                  req_any;
  logic [IW-1:0]         win, idx;
  logic [M_WIDTH-1:0]    sel_addr, sel_data, rdata;
  logic                  sel_we;
  logic [1:0]            sel_w;
  logic [OFFW-1:0]       sel_off;
  logic [CLIENT_CNT*M_WIDTH-1:0] data_ins;

  // Lowest lane touched: 16-bit ignores addr[0], 32-bit ignores addr[1:0]
  function automatic logic [OFFW-1:0] lane_off(input logic [OFFW-1:0] a, input logic [1:0] w);
    case (w)
      2'b00:   return a;
      2'b01:   return a & ~OFFW'(1);
      default: return a & ~OFFW'(3);
    endcase
  endfunction

  function automatic logic [M_WIDTH-1:0] width_mask(input logic [1:0] w);
    case (w)
      2'b00:   return M_WIDTH'(32'h0000_00FF);
      2'b01:   return M_WIDTH'(32'h0000_FFFF);
      default: return M_WIDTH'(32'hFFFF_FFFF);
    endcase
  endfunction

  function automatic logic [NB-1:0] byte_mask(input logic [1:0] w);
    case (w)
      2'b00:   return NB'(4'b0001);
      2'b01:   return NB'(4'b0011);
      default: return NB'(4'b1111);
    endcase
  endfunction

  // Round-robin pick starting after the last grant, then mux out the winner's request
  always_comb begin
    req_any  = 1'b0;
    win      = '0;
    idx      = '0;
    sel_addr = '0;
    sel_data = '0;
    sel_we   = 1'b0;
    sel_w    = '0;
    for (int unsigned k = 0; k < CLIENT_CNT; k++) begin
      idx = IW'((32'(last_q) + 32'd1 + k) % CLIENT_CNT);
      if (!req_any && bus.client_requests[idx]) begin
        req_any = 1'b1;
        win     = idx;
      end
    end
    for (int unsigned i = 0; i < CLIENT_CNT; i++) begin
      if (IW'(i) == win) begin
        sel_addr = bus.client_addrs_packed[i*M_WIDTH +: M_WIDTH];
        sel_data = bus.client_data_outs_packed[i*M_WIDTH +: M_WIDTH];
        sel_we   = bus.client_wes[i];
        sel_w    = bus.client_data_widths_packed[i*2 +: 2];
      end
    end
    sel_off = lane_off(OFFW'(sel_addr), sel_w);
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    we_d       = we_q;
    off_d      = off_q;
    width_d    = width_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = '0;
    mem_we_d   = '0;
    readies_d  = '0;
    case (state_q)
      IDLE: begin
        mem_addr_d = '0;
        if (req_any) begin
          state_d    = ACCESS;
          grant_d    = win;
          last_d     = win;
          we_d       = sel_we;
          off_d      = sel_off;
          width_d    = sel_w;
          mem_addr_d = AW'(sel_addr >> OFFW);
          mem_data_d = (sel_data & width_mask(sel_w)) << (32'(sel_off) * 8);
          mem_we_d   = sel_we ? NB'(byte_mask(sel_w) << sel_off) : '0;
        end
      end
      ACCESS: begin
        state_d   = RESPOND;
        readies_d = CLIENT_CNT'(1) << grant_q;
      end
      RESPOND: begin
        state_d    = IDLE;
        mem_addr_d = '0;
      end
      default: begin
        state_d    = IDLE;
        mem_addr_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= IW'(CLIENT_CNT - 1);
      we_q       <= 1'b0;
      off_q      <= '0;
      width_q    <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_we_q   <= '0;
      readies_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      we_q       <= we_d;
      off_q      <= off_d;
      width_q    <= width_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_we_q   <= mem_we_d;
      readies_q  <= readies_d;
    end
  end

  // Read data arrives from memory during RESPOND, so it is steered straight through
  always_comb begin
    rdata    = (bus.mem_data_in >> (32'(off_q) * 8)) & width_mask(width_q);
    data_ins = '0;
    for (int unsigned i = 0; i < CLIENT_CNT; i++) begin
      if (state_q == RESPOND && !we_q && IW'(i) == grant_q) begin
        data_ins[i*M_WIDTH +: M_WIDTH] = rdata;
      end
    end
  end

  assign bus.client_readies         = readies_q;
  assign bus.client_data_ins_packed = data_ins;
  assign bus.mem_addr               = mem_addr_q;
  assign bus.mem_data_out           = mem_data_q;
  assign bus.mem_we_outs            = mem_we_q;
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: directed scenarios followed by random client traffic,
// all outputs compared every cycle against a transaction-level reference model.
module tb_mem_rr_arbiter;
  localparam int unsigned MW = 32;
  localparam int unsigned CC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_rr_arbiter_if #(.M_WIDTH(MW), .CLIENT_CNT(CC)) bus ();
  mem_rr_arbiter #(.M_WIDTH(MW), .CLIENT_CNT(CC)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0] mem [16];
  always @(posedge clk) bus.mem_data_in <= mem[bus.mem_addr[3:0]];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic        req  [CC];
  logic [31:0] addr [CC];
  logic        we   [CC];
  logic [1:0]  wd   [CC];
  logic [31:0] dat  [CC];

  // Reference model: phase 0 free, 1 memory access, 2 response
  int          m_phase = 0;
  int          m_last  = CC - 1;
  int          m_cli   = 0;
  logic [31:0] m_addr, m_d;
  logic        m_we;
  logic [1:0]  m_w;

  logic [29:0] e_addr;
  logic [3:0]  e_we, e_rdy;
  logic [31:0] e_mdata;
  bit          e_chk_data;
  logic [31:0] e_din [CC];

  logic [3:0]  seen;
  logic [31:0] seen_din [CC];
  int          ready_log [$];
  int          ready_cyc [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int nbytes(input logic [1:0] w);
    return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
  endfunction

  task automatic drive();
    for (int c = 0; c < CC; c++) begin
      bus.client_requests[c]                 = req[c];
      bus.client_addrs_packed[c*32 +: 32]    = addr[c];
      bus.client_wes[c]                      = we[c];
      bus.client_data_widths_packed[c*2 +: 2] = wd[c];
      bus.client_data_outs_packed[c*32 +: 32] = dat[c];
    end
  endtask

  // Predict the cycle following the next rising edge from the current inputs
  task automatic model_step();
    int nb;
    int base;
    bit found;
    logic [31:0] word;
    if (rst) begin
      m_phase = 0;
      m_last  = CC - 1;
    end else if (m_phase == 0) begin
      found = 1'b0;
      for (int k = 0; k < CC; k++) begin
        int j;
        j = (m_last + 1 + k) % CC;
        if (!found && req[j]) begin
          found = 1'b1;
          m_cli = j;
        end
      end
      if (found) begin
        m_addr  = addr[m_cli];
        m_we    = we[m_cli];
        m_w     = wd[m_cli];
        m_d     = dat[m_cli];
        m_last  = m_cli;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else begin
      m_phase = 0;
    end

    e_addr = '0; e_we = '0; e_mdata = '0; e_rdy = '0; e_chk_data = 1'b1;
    for (int c = 0; c < CC; c++) e_din[c] = '0;
    nb   = nbytes(m_w);
    base = (int'(m_addr % 4) / nb) * nb;
    if (m_phase == 1) begin
      e_addr     = 30'(m_addr >> 2);
      e_chk_data = m_we;
      if (m_we) begin
        for (int b = 0; b < nb; b++) begin
          e_we[base + b] = 1'b1;
          e_mdata[8*(base + b) +: 8] = m_d[8*b +: 8];
        end
      end
    end else if (m_phase == 2) begin
      e_addr       = 30'(m_addr >> 2);
      e_chk_data   = 1'b0;
      e_rdy[m_cli] = 1'b1;
      if (!m_we) begin
        word = mem[(m_addr >> 2) % 16];
        for (int b = 0; b < nb; b++) e_din[m_cli][8*b +: 8] = word[8*(base + b) +: 8];
      end
    end
  endtask

  task automatic step();
    drive();
    model_step();
    @(negedge clk);
    cyc++;
    chk("mem_addr", 64'(bus.mem_addr), 64'(e_addr));
    chk("mem_we_outs", 64'(bus.mem_we_outs), 64'(e_we));
    if (e_chk_data) chk("mem_data_out", 64'(bus.mem_data_out), 64'(e_mdata));
    chk("client_readies", 64'(bus.client_readies), 64'(e_rdy));
    seen = bus.client_readies;
    for (int c = 0; c < CC; c++) begin
      seen_din[c] = bus.client_data_ins_packed[c*32 +: 32];
      chk($sformatf("data_in%0d", c), 64'(seen_din[c]), 64'(e_din[c]));
      if (seen[c]) begin
        ready_log.push_back(c);
        ready_cyc.push_back(cyc);
      end
    end
  endtask

  task automatic set_txn(input int c, input logic [31:0] a, input logic w_e,
                         input logic [1:0] w, input logic [31:0] d);
    addr[c] = a; we[c] = w_e; wd[c] = w; dat[c] = d;
  endtask

  task automatic new_txn(input int c);
    logic [1:0] w;
    logic [31:0] m;
    w = 2'($urandom);
    m = (w == 2'd0) ? 32'h0000_00FF : (w == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    set_txn(c, 32'($urandom_range(0, 63)), 1'($urandom), w, $urandom & m);
  endtask

  task automatic run_until_ready(input int c, output logic [31:0] rd);
    bit done;
    done = 1'b0;
    rd   = '0;
    for (int i = 0; i < 12 && !done; i++) begin
      step();
      if (seen[c]) begin
        done = 1'b1;
        rd   = seen_din[c];
      end
    end
    req[c] = 1'b0;
    chk($sformatf("ready%0d_arrived", c), 64'(done), 64'(1));
  endtask

  initial begin
    logic [31:0] rd;
    int t0, n0, cnt;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    for (int c = 0; c < CC; c++) begin
      req[c] = 1'b0;
      set_txn(c, '0, 1'b0, 2'd0, '0);
    end

    rst = 1'b1; step(); step();
    rst = 1'b0; step();

    // Single 32-bit read, with latency from the sampling IDLE cycle
    mem[4] = 32'h1234_5678;
    set_txn(1, 32'h10, 1'b0, 2'd2, 32'h0);
    req[1] = 1'b1;
    t0 = cyc;
    run_until_ready(1, rd);
    chk("single_read_data", 64'(rd), 64'(32'h1234_5678));
    chk("single_read_latency", 64'(ready_cyc[$] - t0), 64'(2));
    step();

    // Byte write into lane 2 of word 0x400
    set_txn(3, 32'h1002, 1'b1, 2'd0, 32'hAB);
    req[3] = 1'b1;
    run_until_ready(3, rd);
    chk("byte_write_din", 64'(rd), 64'(0));
    step();

    // Half-word reads from both halves of one word
    mem[1] = 32'hCAFE_BEEF;
    set_txn(2, 32'h6, 1'b0, 2'd1, 32'h0);
    req[2] = 1'b1;
    run_until_ready(2, rd);
    chk("half_read_hi", 64'(rd), 64'(32'h0000_CAFE));
    step();
    set_txn(2, 32'h4, 1'b0, 2'd1, 32'h0);
    req[2] = 1'b1;
    run_until_ready(2, rd);
    chk("half_read_lo", 64'(rd), 64'(32'h0000_BEEF));
    step();

    // Request withdrawn right after grant still completes once
    set_txn(0, 32'h20, 1'b0, 2'd2, 32'h0);
    req[0] = 1'b1;
    step();
    req[0] = 1'b0;
    n0 = ready_log.size();
    for (int i = 0; i < 4; i++) step();
    cnt = 0;
    for (int i = n0; i < ready_log.size(); i++) if (ready_log[i] == 0) cnt++;
    chk("withdraw_ready_count", 64'(cnt), 64'(1));

    // Fairness with every request held high from reset
    rst = 1'b1; step(); rst = 1'b0;
    ready_log.delete(); ready_cyc.delete();
    for (int c = 0; c < CC; c++) begin new_txn(c); req[c] = 1'b1; end
    for (int i = 0; i < 16; i++) begin
      step();
      for (int c = 0; c < CC; c++) if (seen[c]) new_txn(c);
    end
    chk("fair_ready_count", 64'(ready_log.size() >= 5), 64'(1));
    if (ready_log.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk($sformatf("fair_order%0d", i), 64'(ready_log[i]), 64'(i % CC));
      for (int i = 1; i < 5; i++) chk($sformatf("fair_gap%0d", i), 64'(ready_cyc[i] - ready_cyc[i-1]), 64'(3));
    end
    for (int c = 0; c < CC; c++) req[c] = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Reset during the ACCESS cycle of a write
    rst = 1'b1; step(); rst = 1'b0;
    set_txn(2, 32'h8, 1'b1, 2'd2, 32'h5555_AAAA);
    req[2] = 1'b1;
    step();
    chk("rst_write_we_access", 64'(bus.mem_we_outs), 64'(4'hF));
    rst = 1'b1; req[2] = 1'b0;
    ready_log.delete(); ready_cyc.delete();
    step();
    chk("rst_write_we_after", 64'(bus.mem_we_outs), 64'(0));
    rst = 1'b0;
    new_txn(0); req[0] = 1'b1; req[2] = 1'b1;
    run_until_ready(0, rd);
    chk("rst_first_grant", 64'(ready_log.size() > 0 ? ready_log[0] : -1), 64'(0));

    // Random traffic, occasional withdraw-after-grant and reset
    for (int i = 0; i < 700; i++) begin
      step();
      rst = ($urandom_range(0, 99) == 0);
      for (int c = 0; c < CC; c++) begin
        if (seen[c]) begin
          if ($urandom_range(0, 1) == 1) new_txn(c);
          else req[c] = 1'b0;
        end else if (!req[c]) begin
          if ($urandom_range(0, 2) == 0) begin new_txn(c); req[c] = 1'b1; end
        end else if (m_phase != 0 && m_cli == c && $urandom_range(0, 7) == 0) begin
          req[c] = 1'b0;
        end
      end
    end
    rst = 1'b0;
    for (int c = 0; c < CC; c++) req[c] = 1'b0;
    for (int i = 0; i < 4; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
